breath_pwm_multi: RTL and testbench

BREATH_PWM_MULTI -- requirements
Module: breath_pwm_multi

---
 rtl/breath_pwm_multi.sv | 179 +++++++++++++++++
 tb/tb_breath_pwm_multi.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/breath_pwm_multi.sv
// Multi-channel LED breathing PWM: shared prescaler and PWM counter, per-channel
// breathe FSM with phase offset, plus off / fixed-duty / blink modes.
module breath_pwm_multi #(
  parameter int CH       = 3,
  parameter int BITS     = 10,
  parameter int RANGE    = 999,
  parameter int TICK_DIV = 12000,
  parameter int STEP     = 1,
  parameter int HOLD     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [BITS-1:0] duty,
  output logic [CH-1:0]   led,
  output logic            peak
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  localparam logic [1:0] M_OFF     = 2'd0;
  localparam logic [1:0] M_BREATHE = 2'd1;
  localparam logic [1:0] M_FIXED   = 2'd2;
  localparam logic [1:0] M_BLINK   = 2'd3;

  typedef enum logic [1:0] {S_UP, S_HOLD_HI, S_DOWN, S_HOLD_LO} state_e;

  logic [PW-1:0]   presc_q, presc_d;
  logic [BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [1:0]      mode_q;
  logic            blink_on_q, blink_on_d;
  logic [DW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            peak_q, peak_hit;
  logic            tick, pwm_wrap, mode_chg, breathe_tick;
  logic [BITS-1:0] fixed_lvl;

  assign tick         = en && (presc_q == PW'(TICK_DIV - 1));
  assign pwm_wrap     = (pwm_cnt_q == BITS'(RANGE));
  assign mode_chg     = (mode != mode_q);
  assign breathe_tick = tick && !mode_chg && (mode == M_BREATHE);
  assign fixed_lvl    = (duty > BITS'(RANGE)) ? BITS'(RANGE) : duty;
  assign peak         = peak_q;

  always_comb begin
    presc_d = presc_q;
    if (en) presc_d = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
  end

  // Blink level is shared by every channel and toggles after HOLD+1 ticks.
  always_comb begin
    blink_on_d  = blink_on_q;
    blink_cnt_d = blink_cnt_q;
    if (mode_chg) begin
      blink_on_d  = 1'b1;
      blink_cnt_d = '0;
    end else if (tick && (mode == M_BLINK)) begin
      if (blink_cnt_q == DW'(HOLD)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      mode_q      <= M_OFF;
      blink_on_q  <= 1'b1;
      blink_cnt_q <= '0;
      peak_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      mode_q      <= mode;
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
      peak_q      <= peak_hit;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    localparam logic [BITS-1:0] INIT = BITS'((gi * RANGE) / CH);

    state_e          state_q, state_d;
    logic [BITS-1:0] level_q, level_d, target, active_q;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [BITS:0]   up_sum, dn_diff;

    // One extra bit so the step can overshoot/undershoot before saturation.
    assign up_sum  = {1'b0, level_q} + (BITS+1)'(STEP);
    assign dn_diff = {1'b0, level_q} - (BITS+1)'(STEP);

    always_comb begin
      state_d = state_q;
      level_d = level_q;
      dwell_d = dwell_q;
      if (mode_chg) begin
        state_d = S_UP;
        level_d = INIT;
        dwell_d = '0;
      end else if (breathe_tick) begin
        case (state_q)
          S_UP: begin
            if (up_sum >= (BITS+1)'(RANGE)) begin
              level_d = BITS'(RANGE);
              state_d = (HOLD > 0) ? S_HOLD_HI : S_DOWN;
              dwell_d = '0;
            end else begin
              level_d = up_sum[BITS-1:0];
            end
          end
          S_DOWN: begin
            if (dn_diff[BITS] || (dn_diff == '0)) begin
              level_d = '0;
              state_d = (HOLD > 0) ? S_HOLD_LO : S_UP;
              dwell_d = '0;
            end else begin
              level_d = dn_diff[BITS-1:0];
            end
          end
          S_HOLD_HI: begin
            if (dwell_q == DW'(HOLD - 1)) begin
              state_d = S_DOWN;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
          S_HOLD_LO: begin
            if (dwell_q == DW'(HOLD - 1)) begin
              state_d = S_UP;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
          default: state_d = S_UP;
        endcase
      end
    end

    always_comb begin
      target = '0;
      case (mode)
        M_BREATHE: target = level_q;
        M_FIXED:   target = fixed_lvl;
        M_BLINK:   target = blink_on_q ? BITS'(RANGE) : '0;
        default:   target = '0;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q  <= S_UP;
        level_q  <= INIT;
        dwell_q  <= '0;
        active_q <= '0;
      end else begin
        state_q  <= state_d;
        level_q  <= level_d;
        dwell_q  <= dwell_d;
        if (pwm_wrap) active_q <= target;
      end
    end

    assign led[gi] = (pwm_cnt_q < active_q);

    if (gi == 0) begin : g_peak
      assign peak_hit = breathe_tick && (state_q == S_UP) && (up_sum >= (BITS+1)'(RANGE));
    end
  end

endmodule

// File: tb/tb_breath_pwm_multi.sv
// Directed bench for breath_pwm_multi: two instances (HOLD=0 and HOLD=2) share stimulus.
module tb_breath_pwm_multi;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic [3:0] duty;
  logic [1:0] led0, led1;
  logic       peak0, peak1;
  int         errors = 0;
  int         checks = 0;
  int         peak_cnt0 = 0;
  int         peak_cnt1 = 0;

  always #5 clk = ~clk;

  breath_pwm_multi #(.CH(2), .BITS(4), .RANGE(9), .TICK_DIV(4), .STEP(3), .HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .duty(duty), .led(led0), .peak(peak0));

  breath_pwm_multi #(.CH(2), .BITS(4), .RANGE(9), .TICK_DIV(4), .STEP(3), .HOLD(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .duty(duty), .led(led1), .peak(peak1));

  always @(negedge clk) begin
    if (peak0 === 1'b1) peak_cnt0++;
    if (peak1 === 1'b1) peak_cnt1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick1();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_leds(input int n, output int c00, output int c01,
                            output int c10, output int c11);
    c00 = 0; c01 = 0; c10 = 0; c11 = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      c00 += int'(led0[0]);
      c01 += int'(led0[1]);
      c10 += int'(led1[0]);
      c11 += int'(led1[1]);
    end
  endtask

  initial begin
    int d0c0[10] = '{3, 6, 9, 6, 3, 0, 3, 6, 9, 6};
    int d0c1[10] = '{7, 9, 6, 3, 0, 3, 6, 9, 6, 3};
    int d1c0[10] = '{3, 6, 9, 9, 9, 6, 3, 0, 0, 0};
    int c00, c01, c10, c11;
    bit found;

    rst = 1'b0; en = 1'b0; mode = 2'd1; duty = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_led0", led0, 0);
    chk("rst_led1", led1, 0);
    chk("rst_peak0", peak0, 0);
    chk("rst_lvl_ch0", dut0.g_ch[0].level_q, 0);
    chk("rst_lvl_ch1", dut0.g_ch[1].level_q, 4);
    chk("rst_lvl1_ch1", dut1.g_ch[1].level_q, 4);

    rst = 1'b1; en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("no_early_tick", dut0.g_ch[0].level_q, 0);
    @(posedge clk);
    @(negedge clk);
    for (int t = 0; t < 10; t++) begin
      if (t > 0) tick1();
      chk($sformatf("h0_ch0_t%0d", t + 1), dut0.g_ch[0].level_q, d0c0[t]);
      chk($sformatf("h0_ch1_t%0d", t + 1), dut0.g_ch[1].level_q, d0c1[t]);
      chk($sformatf("h2_ch0_t%0d", t + 1), dut1.g_ch[0].level_q, d1c0[t]);
      chk($sformatf("peak0_t%0d", t + 1), peak0, (t == 2 || t == 8) ? 1 : 0);
      chk($sformatf("peak1_t%0d", t + 1), peak1, (t == 2) ? 1 : 0);
    end
    chk("peak0_count", peak_cnt0, 2);
    chk("peak1_count", peak_cnt1, 1);

    en = 1'b0;
    repeat (10) @(negedge clk);
    count_leds(10, c00, c01, c10, c11);
    chk("frz_duty_h0c0", c00, 6);
    chk("frz_duty_h0c1", c01, 3);
    chk("frz_duty_h2c0", c10, 0);
    chk("frz_lvl_h0c0", dut0.g_ch[0].level_q, 6);
    en = 1'b1;
    tick1();
    chk("resume_h0c0", dut0.g_ch[0].level_q, 3);
    chk("resume_h0c1", dut0.g_ch[1].level_q, 0);
    chk("resume_h2c0", dut1.g_ch[0].level_q, 3);

    tick1();
    tick1();
    chk("hold_lvl_h2c0", dut1.g_ch[0].level_q, 9);
    chk("hold_peak1", peak1, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_led0", led0, 0);
    chk("arst_led1", led1, 0);
    chk("arst_peak1", peak1, 0);
    chk("arst_lvl_h2c0", dut1.g_ch[0].level_q, 0);
    chk("arst_lvl_h2c1", dut1.g_ch[1].level_q, 4);
    @(negedge clk);
    rst = 1'b1;
    tick1();
    chk("rel_h0c0", dut0.g_ch[0].level_q, 3);
    chk("rel_h2c1", dut1.g_ch[1].level_q, 7);

    mode = 2'd2; duty = 4'd15;
    repeat (20) @(negedge clk);
    count_leds(10, c00, c01, c10, c11);
    chk("fix15_h0c0", c00, 9);
    chk("fix15_h0c1", c01, 9);
    chk("fix15_h2c0", c10, 9);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (dut0.pwm_cnt_q == 4'd4) found = 1'b1;
    end
    chk("find_pwm4", found, 1);
    duty = 4'd3;
    count_leds(5, c00, c01, c10, c11);
    chk("fix_old_tail", c00, 4);
    count_leds(10, c00, c01, c10, c11);
    chk("fix3_h0c0", c00, 3);
    chk("fix3_h2c1", c11, 3);

    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (dut0.presc_q == 2'd0) found = 1'b1;
    end
    chk("find_presc0", found, 1);
    mode = 2'd1;
    tick1();
    chk("reinit_h0c0", dut0.g_ch[0].level_q, 3);
    chk("reinit_h0c1", dut0.g_ch[1].level_q, 7);

    en = 1'b0; mode = 2'd3;
    repeat (10) @(negedge clk);
    count_leds(10, c00, c01, c10, c11);
    chk("blink_on_h0c0", c00, 9);
    chk("blink_on_h0c1", c01, 9);
    chk("blink_on_h2c0", c10, 9);
    chk("blink_on_h2c1", c11, 9);
    chk("blink_reinit", dut0.g_ch[0].level_q, 0);
    en = 1'b1;
    tick1();
    chk("blink_h0_t1", dut0.blink_on_q, 0);
    chk("blink_h2_t1", dut1.blink_on_q, 1);
    tick1();
    tick1();
    chk("blink_h0_t3", dut0.blink_on_q, 0);
    chk("blink_h2_t3", dut1.blink_on_q, 0);
    tick1();
    tick1();
    tick1();
    chk("blink_h0_t6", dut0.blink_on_q, 1);
    chk("blink_h2_t6", dut1.blink_on_q, 1);

    mode = 2'd0;
    repeat (10) @(negedge clk);
    count_leds(10, c00, c01, c10, c11);
    chk("off_h0c0", c00, 0);
    chk("off_h2c1", c11, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
